// File: rtl/flit_msg_deserializer_pkg.sv
// Shared encodings for the flit message deserializer: flit ctrl codes and fill-FSM states.
package flit_pkg;

    localparam logic [1:0] FLIT_RSVD = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WAIT = 2'b10
    } fill_state_e;

endpackage

// File: rtl/flit_msg_deserializer_if.sv
// Ingress flit stream and egress message port of the flit message deserializer.
interface flit_msg_deserializer_if
    import flit_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = $clog2(MAX_FLITS + 1)
);
    logic [FLIT_W-1:0]           in_flit;
    logic                        in_valid;
    logic [1:0]                  in_ctrl;
    logic                        in_ready;
    logic                        msg_valid;
    logic [FLIT_W*MAX_FLITS-1:0] msg_flits;
    logic [CNT_W-1:0]            msg_len;
    logic                        msg_err;
    logic                        msg_done;
    logic [1:0]                  fill_state;

    modport master (
        output in_flit, in_valid, in_ctrl, msg_done,
        input  in_ready, msg_valid, msg_flits, msg_len, msg_err, fill_state
    );

    modport slave (
        input  in_flit, in_valid, in_ctrl, msg_done,
        output in_ready, msg_valid, msg_flits, msg_len, msg_err, fill_state
    );
endinterface

// File: rtl/flit_msg_deserializer_buffer.sv
// One message buffer: flit slots written at index len, saturating length, sticky error and full flag.
module flit_msg_buffer
    import flit_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = $clog2(MAX_FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [FLIT_W-1:0]           wr_flit,
    input  logic                        set_err,
    input  logic                        set_full,
    input  logic                        clear,
    output logic [FLIT_W*MAX_FLITS-1:0] flits,
    output logic [CNT_W-1:0]            len,
    output logic                        err,
    output logic                        full
);
    logic [MAX_FLITS-1:0] slot_sel;
    logic                 ovf;

    assign ovf = (len == CNT_W'(MAX_FLITS));

    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (len == CNT_W'(k)) slot_sel[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            flits <= '0;
            len   <= '0;
            err   <= 1'b0;
            full  <= 1'b0;
        end else begin
            // Flits past the last slot are dropped and only mark the message bad.
            if (wr_en) begin
                if (ovf) begin
                    err <= 1'b1;
                end else begin
                    for (int k = 0; k < MAX_FLITS; k++) begin
                        if (slot_sel[k]) flits[k*FLIT_W +: FLIT_W] <= wr_flit;
                    end
                    len <= len + CNT_W'(1);
                end
            end
            if (set_err)  err  <= 1'b1;
            if (set_full) full <= 1'b1;
        end
    end
endmodule

// File: rtl/flit_msg_deserializer.sv
// Collects flit messages into two ping-pong buffers and presents each as one wide word.
// state | meaning
// IDLE  | waiting for the first flit of a message
// BUSY  | collecting body flits until the tail
// WAIT  | next target buffer still held by the consumer
module flit_msg_deserializer
    import flit_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = $clog2(MAX_FLITS + 1)
) (
    input logic                    clk,
    input logic                    rst,
    flit_msg_deserializer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_WAIT = WAIT;

    logic [1:0] state;
    logic       wr_ptr;
    logic       rd_ptr;

    logic [FLIT_W*MAX_FLITS-1:0] buf_flits [2];
    logic [CNT_W-1:0]            buf_len   [2];
    logic [1:0]                  buf_err;
    logic [1:0]                  buf_full;

    logic       accept, is_tail, head_err, rel_en, next_busy;
    logic [1:0] wr_en, set_err, set_full, clear;

    assign bus.in_ready = (state != ST_WAIT) && !buf_full[wr_ptr];
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_tail      = (bus.in_ctrl == FLIT_TAIL);
    assign head_err     = (state == ST_BUSY) && (bus.in_ctrl == FLIT_HEAD);
    assign rel_en       = bus.msg_done && buf_full[rd_ptr];
    // Target after a tail may be freed in the same cycle, which keeps it accept-capable.
    assign next_busy    = buf_full[~wr_ptr] && !(rel_en && (rd_ptr == ~wr_ptr));

    always_comb begin
        wr_en    = '0;
        set_err  = '0;
        set_full = '0;
        clear    = '0;
        wr_en[wr_ptr]    = accept;
        set_err[wr_ptr]  = accept && head_err;
        set_full[wr_ptr] = accept && is_tail;
        clear[rd_ptr]    = rel_en;
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        flit_msg_buffer #(
            .FLIT_W    (FLIT_W),
            .MAX_FLITS (MAX_FLITS),
            .CNT_W     (CNT_W)
        ) u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[g]),
            .wr_flit  (bus.in_flit),
            .set_err  (set_err[g]),
            .set_full (set_full[g]),
            .clear    (clear[g]),
            .flits    (buf_flits[g]),
            .len      (buf_len[g]),
            .err      (buf_err[g]),
            .full     (buf_full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (rel_en) rd_ptr <= ~rd_ptr;
            case (state)
                ST_IDLE, ST_BUSY: begin
                    if (accept) begin
                        if (is_tail) begin
                            wr_ptr <= ~wr_ptr;
                            state  <= next_busy ? ST_WAIT : ST_IDLE;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_WAIT: if (!buf_full[wr_ptr]) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.msg_valid  = buf_full[rd_ptr];
    assign bus.msg_flits  = buf_flits[rd_ptr];
    assign bus.msg_len    = buf_len[rd_ptr];
    assign bus.msg_err    = buf_err[rd_ptr];
    assign bus.fill_state = state;
endmodule

// File: doc/flit_msg_deserializer.md
# flit_msg_deserializer

Parametrised successor to the memory-side download block: collects a variable-length message of `FLIT_W`-bit flits from the ring network and presents it as one wide word to the memory/cache controller. It has two ping-pong message buffers, so a new message can arrive while the previous one waits for the consumer. It also provides ingress back-pressure, a message length output and an overflow/protocol error flag.

## Interface
- `FLIT_W`, 16, flit width in bits
- `MAX_FLITS`, 11, flits per message buffer (≥2)
- `CNT_W`, $clog2(MAX_FLITS+1), width of the length field
- `clk` in 1: clock
- `rst` in 1: reset. Synchronous, active-high. Clock is `clk`.
- `in_flit` in FLIT_W: incoming flit
- `in_valid` in 1: flit valid
- `in_ctrl` in 2: flit type; 01 head, 10 body, 11 tail, 00 reserved
- `in_ready` out 1: flit is accepted in a cycle where `in_valid && in_ready`
- `msg_valid` out 1: a complete message is presented
- `msg_flits` out FLIT_W*MAX_FLITS: flit k sits at bits [k*FLIT_W +: FLIT_W]; unfilled slots are 0
- `msg_len` out CNT_W: number of flits stored, 1..MAX_FLITS
- `msg_err` out 1: the presented message overflowed or violated the protocol
- `msg_done` in 1: consumer releases the presented message
- `fill_state` out 2: fill FSM state, for debug/status

## Operation
- Two buffers, B0 and B1. Each buffer holds `full`, `len`, `err` and MAX_FLITS flit registers.
- `wr_ptr` selects the buffer being filled. `rd_ptr` selects the buffer being presented.
- Fill FSM states:
  - IDLE = 00.
  - BUSY = 01.
  - WAIT = 10: the target buffer is still full.
- IDLE, on accept: store the flit in slot 0 and set len = 1.
  - If ctrl = 11, the message is a single flit: complete it.
  - Otherwise go to BUSY. Any ctrl other than 11 is accepted as the first flit.
- BUSY, on accept: store the flit in slot len and increment len.
  - ctrl = 11: complete the message.
  - ctrl = 01 (a head while busy): set err; the flit is stored as a body flit.
- Overflow: once len = MAX_FLITS, further flits are accepted and discarded, err is set, len saturates, and the FSM waits for the tail.
- Complete: set full[wr_ptr] and toggle wr_ptr.
  - Go to IDLE if the new target buffer is empty, else go to WAIT.
- WAIT: `in_ready` is 0. Go to IDLE in the cycle after the target buffer is freed.
- `in_ready` = (state ≠ WAIT) && !full[wr_ptr].
- Read side:
  - `msg_valid` = full[rd_ptr].
  - `msg_flits`, `msg_len` and `msg_err` all come from buffer rd_ptr.
- `msg_done && msg_valid`: clear buffer rd_ptr (flits, len and err to 0; full to 0) and toggle rd_ptr.
- `msg_done` while `!msg_valid`: ignored.
- Tail accept and release in the same cycle: both take effect. They always target different buffers.
- Reset, including mid-message: both buffers cleared, both pointers = 0, FSM = IDLE. A partial message is discarded.

## Timing
- Values after the first reset edge:
  - `msg_valid` = 0.
  - `msg_flits` = 0, `msg_len` = 0, `msg_err` = 0.
  - `fill_state` = 00.
  - `in_ready` = 1.
- Flit storage latency: the flit accepted at edge N is visible in the buffer after edge N.
- The tail is accepted at edge N:
  - `msg_valid` = 1 after edge N, if that buffer is rd_ptr.
  - Otherwise `msg_valid` rises after the release of the other buffer.
- Release: `msg_done` is sampled at edge N. After edge N:
  - the next message is presented if the other buffer is full (`msg_valid` stays 1), else `msg_valid` = 0.
  - Holding `msg_done` high releases one message per cycle.
- Throughput: one flit per cycle. The cycle after a tail accept is also accept-capable whenever the other buffer is free.
- Outputs are purely registered plus one 2:1 mux. There is no combinational path from inputs to outputs except `in_ready` ← state/full.

## Structure
- Package `flit_pkg`:
  - ctrl encodings FLIT_HEAD/BODY/TAIL.
  - fill-state enum IDLE/BUSY/WAIT.
- Sub-module `flit_msg_buffer`, parametrised by FLIT_W and MAX_FLITS, instantiated twice. Per buffer it provides:
  - inputs: write enable, ctrl-decoded set_err, set_full and clear.
  - outputs: flit array, len, err and full.
  - the one-hot slot decode from len.
- Top level holds the fill FSM, both pointers, and the output mux.

## Test plan
- 11-flit message (head 0x1000, bodies 0x1001..0x1009, tail 0x100A) with `msg_done` low → `msg_valid` = 1 the cycle after the tail; `msg_len` = 11; `msg_flits` = {0x100A,...,0x1000}; `msg_err` = 0.
- Single flit with ctrl = 11, data 0xBEEF → `msg_len` = 1; slot 0 = 0xBEEF; all other slots 0.
- Two back-to-back 3-flit messages with no `msg_done`, then a third head → `in_ready` = 0 and `fill_state` = WAIT. Pulse `msg_done` → the second message is presented the next cycle; `in_ready` returns 1 the cycle after that.
- 13-flit message with MAX_FLITS = 11 → `msg_len` = 11; flits 12 and 13 are dropped; `msg_err` = 1. The following message has `msg_err` = 0.
- Head, body, head, tail → `msg_err` = 1 and `msg_len` = 4.
- `rst` pulsed after 5 flits of a message → all outputs 0. A fresh 2-flit message then completes with `msg_len` = 2 and no stale data.
